// File: rtl/bsg_counter_overflow_chan.sv
// One counter channel: registered count, compare against a runtime limit,
// and a sticky flag that remembers any wrap until software clears it.
module bsg_counter_overflow_chan #(
  parameter int width_p      = 8,
  parameter int step_width_p = 4,
  parameter int init_val_p   = 0,
  parameter bit saturate_p   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [step_width_p-1:0] step_i,
  input  logic [width_p-1:0]      max_i,
  input  logic                    clear_i,
  input  logic                    sticky_clr_i,
  output logic [width_p-1:0]      count_o,
  output logic                    wrap_o,
  output logic                    at_max_o,
  output logic                    sticky_o
);

  localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);

  logic [width_p-1:0] count_reg, count_next;
  logic               sticky_reg, sticky_next;
  logic [width_p:0]   sum;

  // One extra bit so a sum past the top of the counter still compares as "over".
  assign sum      = {1'b0, count_reg} + (width_p + 1)'(step_i);
  assign wrap_o   = en_i & (sum > {1'b0, max_i});
  assign at_max_o = (count_reg == max_i);
  assign count_o  = count_reg;
  assign sticky_o = sticky_reg;

  always_comb begin
    count_next = count_reg;
    if (clear_i)
      count_next = init_lp;
    else if (wrap_o)
      count_next = saturate_p ? max_i : init_lp;
    else if (en_i)
      count_next = sum[width_p-1:0];
  end

  always_comb begin
    sticky_next = sticky_reg;
    if (wrap_o)
      sticky_next = 1'b1;
    else if (sticky_clr_i)
      sticky_next = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_reg  <= init_lp;
      sticky_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      sticky_reg <= sticky_next;
    end
  end

endmodule

// File: rtl/bsg_counter_overflow_multi.sv
// Bank of independent overflow counters; with cascade_p set, each channel
// only advances when the channel below it wraps in the same cycle.
module bsg_counter_overflow_multi #(
  parameter int els_p        = 4,
  parameter int width_p      = 8,
  parameter int step_width_p = 4,
  parameter int init_val_p   = 0,
  parameter bit saturate_p   = 1'b0,
  parameter bit cascade_p    = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [els_p-1:0]                    en_i,
  input  logic [els_p-1:0][step_width_p-1:0]  step_i,
  input  logic [els_p-1:0][width_p-1:0]       max_i,
  input  logic [els_p-1:0]                    clear_i,
  input  logic [els_p-1:0]                    sticky_clr_i,
  output logic [els_p-1:0][width_p-1:0]       count_o,
  output logic [els_p-1:0]                    wrap_o,
  output logic [els_p-1:0]                    at_max_o,
  output logic [els_p-1:0]                    sticky_o
);

  for (genvar gi = 0; gi < els_p; gi++) begin : gen_chan
    logic eff_en;
    logic wrap;

    // Chain through per-block nets so the ripple stays purely combinational.
    if (gi == 0 || !cascade_p) begin : gen_direct
      assign eff_en = en_i[gi];
    end else begin : gen_cascade
      assign eff_en = en_i[gi] & gen_chan[gi-1].wrap;
    end

    bsg_counter_overflow_chan #(
      .width_p     (width_p),
      .step_width_p(step_width_p),
      .init_val_p  (init_val_p),
      .saturate_p  (saturate_p)
    ) chan (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .en_i        (eff_en),
      .step_i      (step_i[gi]),
      .max_i       (max_i[gi]),
      .clear_i     (clear_i[gi]),
      .sticky_clr_i(sticky_clr_i[gi]),
      .count_o     (count_o[gi]),
      .wrap_o      (wrap),
      .at_max_o    (at_max_o[gi]),
      .sticky_o    (sticky_o[gi])
    );

    assign wrap_o[gi] = wrap;
  end

endmodule

// File: tb/tb_bsg_counter_overflow_multi.sv
// Three configurations (wrap, saturate, cascade) driven together; a reference
// model pushes expected outputs per cycle and a monitor pops and compares.
module tb_bsg_counter_overflow_multi;

  localparam int NE   [3] = '{4, 2, 3};
  localparam int INIT [3] = '{0, 3, 0};
  localparam bit SAT  [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit CAS  [3] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bit       en_l[3][4], clr_l[3][4], sclr_l[3][4];
  bit [3:0] step_l[3][4];
  bit [7:0] max_l[3][4];
  bit       p_en[3][4], p_clr[3][4], p_sclr[3][4];
  bit [3:0] p_step[3][4];
  bit [7:0] p_max[3][4];
  bit       rst_p;

  logic [3:0] d0_en, d0_clr, d0_sclr, d0_wrap, d0_atm, d0_stk;
  logic [3:0][3:0] d0_step;
  logic [3:0][7:0] d0_max, d0_cnt;
  logic [1:0] d1_en, d1_clr, d1_sclr, d1_wrap, d1_atm, d1_stk;
  logic [1:0][3:0] d1_step;
  logic [1:0][7:0] d1_max, d1_cnt;
  logic [2:0] d2_en, d2_clr, d2_sclr, d2_wrap, d2_atm, d2_stk;
  logic [2:0][3:0] d2_step;
  logic [2:0][7:0] d2_max, d2_cnt;

  logic [7:0] cnt_a[3][4];
  logic       wrap_a[3][4], atm_a[3][4], stk_a[3][4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      d0_en[k] = en_l[0][k]; d0_clr[k] = clr_l[0][k]; d0_sclr[k] = sclr_l[0][k];
      d0_step[k] = step_l[0][k]; d0_max[k] = max_l[0][k];
    end
    for (int k = 0; k < 2; k++) begin
      d1_en[k] = en_l[1][k]; d1_clr[k] = clr_l[1][k]; d1_sclr[k] = sclr_l[1][k];
      d1_step[k] = step_l[1][k]; d1_max[k] = max_l[1][k];
    end
    for (int k = 0; k < 3; k++) begin
      d2_en[k] = en_l[2][k]; d2_clr[k] = clr_l[2][k]; d2_sclr[k] = sclr_l[2][k];
      d2_step[k] = step_l[2][k]; d2_max[k] = max_l[2][k];
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        cnt_a[d][k] = '0; wrap_a[d][k] = 1'b0; atm_a[d][k] = 1'b0; stk_a[d][k] = 1'b0;
      end
    for (int k = 0; k < 4; k++) begin
      cnt_a[0][k] = d0_cnt[k]; wrap_a[0][k] = d0_wrap[k]; atm_a[0][k] = d0_atm[k]; stk_a[0][k] = d0_stk[k];
    end
    for (int k = 0; k < 2; k++) begin
      cnt_a[1][k] = d1_cnt[k]; wrap_a[1][k] = d1_wrap[k]; atm_a[1][k] = d1_atm[k]; stk_a[1][k] = d1_stk[k];
    end
    for (int k = 0; k < 3; k++) begin
      cnt_a[2][k] = d2_cnt[k]; wrap_a[2][k] = d2_wrap[k]; atm_a[2][k] = d2_atm[k]; stk_a[2][k] = d2_stk[k];
    end
  end

  bsg_counter_overflow_multi #(.els_p(4), .width_p(8), .step_width_p(4),
    .init_val_p(0), .saturate_p(1'b0), .cascade_p(1'b0)) dut_wrap (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(d0_en), .step_i(d0_step), .max_i(d0_max),
    .clear_i(d0_clr), .sticky_clr_i(d0_sclr), .count_o(d0_cnt), .wrap_o(d0_wrap),
    .at_max_o(d0_atm), .sticky_o(d0_stk));

  bsg_counter_overflow_multi #(.els_p(2), .width_p(8), .step_width_p(4),
    .init_val_p(3), .saturate_p(1'b1), .cascade_p(1'b0)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(d1_en), .step_i(d1_step), .max_i(d1_max),
    .clear_i(d1_clr), .sticky_clr_i(d1_sclr), .count_o(d1_cnt), .wrap_o(d1_wrap),
    .at_max_o(d1_atm), .sticky_o(d1_stk));

  bsg_counter_overflow_multi #(.els_p(3), .width_p(8), .step_width_p(4),
    .init_val_p(0), .saturate_p(1'b0), .cascade_p(1'b1)) dut_cas (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(d2_en), .step_i(d2_step), .max_i(d2_max),
    .clear_i(d2_clr), .sticky_clr_i(d2_sclr), .count_o(d2_cnt), .wrap_o(d2_wrap),
    .at_max_o(d2_atm), .sticky_o(d2_stk));

  typedef struct {
    int d;
    int k;
    int cnt;
    bit wrap;
    bit atm;
    bit stk;
  } exp_t;

  exp_t q[$];
  int   m_cnt[3][4];
  bit   m_stk[3][4];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  event ev_sample;

  // Applies pending stimulus at the falling edge, predicts what the DUT shows
  // before the next rising edge, then advances the model past that edge.
  task automatic cycle();
    @(negedge clk);
    en_l = p_en; clr_l = p_clr; sclr_l = p_sclr; step_l = p_step; max_l = p_max;
    reset_n = !rst_p;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      bit prev_wrap = 1'b0;
      for (int k = 0; k < NE[d]; k++) begin
        bit   adv, w;
        int   total;
        exp_t e;
        if (rst_p) begin
          m_cnt[d][k] = INIT[d];
          m_stk[d][k] = 1'b0;
        end
        adv   = en_l[d][k] && (k == 0 || !CAS[d] || prev_wrap);
        total = m_cnt[d][k] + int'(step_l[d][k]);
        w     = adv && (total > int'(max_l[d][k]));
        e.d = d; e.k = k; e.cnt = m_cnt[d][k]; e.wrap = w;
        e.atm = (m_cnt[d][k] == int'(max_l[d][k])); e.stk = m_stk[d][k];
        q.push_back(e);
        if (!rst_p) begin
          if (clr_l[d][k])      m_cnt[d][k] = INIT[d];
          else if (w)           m_cnt[d][k] = SAT[d] ? int'(max_l[d][k]) : INIT[d];
          else if (adv)         m_cnt[d][k] = total % 256;
          if (w)                m_stk[d][k] = 1'b1;
          else if (sclr_l[d][k]) m_stk[d][k] = 1'b0;
        end
        prev_wrap = w;
      end
    end
    -> ev_sample;
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        p_en[d][k] = 1'b0; p_clr[d][k] = 1'b0; p_sclr[d][k] = 1'b0; p_step[d][k] = 4'd0;
      end
  endtask

  task automatic check(input string nm, input int d, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL cyc%0d dut%0d ch%0d %s got=%0d exp=%0d", cyc, d, k, nm, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(ev_sample);
      #2;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("count",  e.d, e.k, int'(cnt_a[e.d][e.k]), e.cnt);
        check("wrap",   e.d, e.k, int'(wrap_a[e.d][e.k]), int'(e.wrap));
        check("at_max", e.d, e.k, int'(atm_a[e.d][e.k]), int'(e.atm));
        check("sticky", e.d, e.k, int'(stk_a[e.d][e.k]), int'(e.stk));
        $display("cyc%0d dut%0d ch%0d count=%0d wrap=%0d at_max=%0d sticky=%0d",
                 cyc, e.d, e.k, cnt_a[e.d][e.k], wrap_a[e.d][e.k], atm_a[e.d][e.k], stk_a[e.d][e.k]);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) p_max[d][k] = 8'd255;
    rst_p = 1'b1;
    repeat (2) cycle();
    rst_p = 1'b0;

    // Wrap sequence 0,4,8 -> wrap -> 0 on the plain bank.
    p_max[0][0] = 8'd9; p_step[0][0] = 4'd4; p_en[0][0] = 1'b1;
    repeat (5) cycle();
    idle();

    // Saturate: climb to 195, then repeated enables pin the count at 200.
    p_max[1][0] = 8'd200; p_step[1][0] = 4'd15; p_en[1][0] = 1'b1;
    repeat (12) cycle();
    p_step[1][0] = 4'd12;
    cycle();
    p_step[1][0] = 4'd15;
    repeat (4) cycle();
    idle();

    // Cascade ripple through three channels with limit 1.
    for (int k = 0; k < 3; k++) begin
      p_max[2][k] = 8'd1; p_step[2][k] = 4'd1; p_en[2][k] = 1'b1;
    end
    repeat (9) cycle();
    // Clear and sticky clear on a wrapping channel; downstream still advances.
    cycle();
    p_clr[2][0] = 1'b1; p_sclr[2][0] = 1'b1;
    cycle();
    idle();
    cycle();

    // Limit lowered below the current count.
    p_clr[0][1] = 1'b1;
    cycle();
    idle();
    p_max[0][1] = 8'd50; p_step[0][1] = 4'd15; p_en[0][1] = 1'b1;
    repeat (2) cycle();
    idle();
    p_max[0][1] = 8'd10;
    repeat (2) cycle();
    p_step[0][1] = 4'd1; p_en[0][1] = 1'b1;
    repeat (2) cycle();
    idle();

    // Asynchronous reset mid-count, then advance on the first edge after release.
    p_max[0][2] = 8'd100; p_step[0][2] = 4'd7; p_en[0][2] = 1'b1;
    cycle();
    idle();
    rst_p = 1'b1;
    cycle();
    rst_p = 1'b0;
    p_step[0][2] = 4'd3; p_en[0][2] = 1'b1;
    repeat (2) cycle();
    idle();

    // Randomized traffic with a fixed legal limit per channel.
    rst_p = 1'b1;
    cycle();
    rst_p = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++)
        p_max[d][k] = 8'(INIT[d] + $urandom_range(0, 255 - INIT[d]));
    for (int d = 0; d < 3; d++) p_max[d][0] = 8'(INIT[d] + $urandom_range(0, 20));
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 3; d++)
        for (int k = 0; k < 4; k++) begin
          p_en[d][k]   = ($urandom_range(0, 3) != 0);
          p_step[d][k] = 4'($urandom_range(0, 15));
          p_clr[d][k]  = ($urandom_range(0, 15) == 0);
          p_sclr[d][k] = ($urandom_range(0, 7) == 0);
        end
      cycle();
    end
    idle();

    #10;
    check("queue_drained", 0, 0, q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_counter_overflow_multi.md
BSG_COUNTER_OVERFLOW_MULTI -- requirements
Module: bsg_counter_overflow_multi

Interface
REQ-001 SHALL have parameter els_p, default 4: number of independent counter channels; must be at least 1.
REQ-002 SHALL have parameter width_p, default 8: count width per channel.
REQ-003 SHALL have parameter step_width_p, default 4: increment width per channel; must be at most width_p.
REQ-004 SHALL have parameter init_val_p, default 0: reload value after reset, clear, or wrap.
REQ-005 SHALL have parameter saturate_p, default 0: 0 selects wrap-to-init mode, 1 selects saturate-at-max mode.
REQ-006 SHALL have parameter cascade_p, default 0: 1 means channel k advances only on channel k-1 wrap.
REQ-007 SHALL have port clk_i, input, 1 bit: single clock.
REQ-008 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port en_i, input, els_p bits: per-channel advance request.
REQ-010 SHALL have port step_i, input, els_p x step_width_p bits: per-channel increment.
REQ-011 SHALL have port max_i, input, els_p x width_p bits: per-channel runtime limit; max_i >= init_val_p required.
REQ-012 SHALL have port clear_i, input, els_p bits: synchronous reload of the count to init_val_p.
REQ-013 SHALL have port sticky_clr_i, input, els_p bits: clears the sticky flag.
REQ-014 SHALL have port count_o, output, els_p x width_p bits: registered count.
REQ-015 SHALL have port wrap_o, output, els_p bits: combinational; this cycle's advance exceeds max.
REQ-016 SHALL have port at_max_o, output, els_p bits: combinational; count_o == max_i.
REQ-017 SHALL have port sticky_o, output, els_p bits: registered; a wrap occurred since the last clear.

Function
REQ-018 The block SHALL compute next[k] = count[k] + step_i[k] at width_p+1 bits, with no truncation before compare.
REQ-019 The effective enable SHALL be eff_en[k] = en_i[k] when k == 0 or cascade_p == 0; otherwise eff_en[k] = en_i[k] & wrap_o[k-1].
REQ-020 wrap_o[k] SHALL equal eff_en[k] & (next[k] > max_i[k]); it is combinational within the same cycle.
REQ-021 The count update priority per rising edge SHALL be: clear_i -> init_val_p; else eff_en & wrap -> init_val_p (saturate_p == 0) or max_i (saturate_p == 1); else eff_en -> next[k] truncated; else hold.
REQ-022 A count at max SHALL NOT auto-reload; it holds until eff_en or clear_i.
REQ-023 A zero step with eff_en SHALL leave the count unchanged and produce no wrap.
REQ-024 When clear_i and eff_en coincide, clear SHALL win for the count, while wrap_o SHALL still reflect the combinational compare and still propagate in cascade.
REQ-025 In saturate mode a channel at max with step > 0 and eff_en SHALL assert wrap_o every such cycle.
REQ-026 sticky_o[k] SHALL be set on the edge where wrap_o[k] = 1 and cleared by sticky_clr_i[k]; on simultaneous set and clear, set wins.
REQ-027 A change of max_i below the current count SHALL cause wrap on the next enabled advance; with no advance the count holds.
REQ-028 The cascade chain SHALL be purely combinational, so a ripple through all els_p channels completes in one cycle.

Reset
REQ-029 While reset_n_i = 0, every count_o SHALL equal init_val_p and every sticky_o SHALL be 0, asynchronously.
REQ-030 Deassertion SHALL take effect at the next clk_i edge; an en_i present on that edge advances the count normally.
REQ-031 Reset asserted mid-operation SHALL discard pending wraps; sticky flags SHALL NOT survive reset.

Structure
REQ-032 No shared package SHALL be used; width derivation SHALL use the standard width macros.
REQ-033 One sub-module, bsg_counter_overflow_chan, SHALL implement a single channel (count, compare, sticky).
REQ-034 The top level SHALL generate els_p channel instances and the eff_en cascade chain.

Verification
REQ-035 Wrap test: width_p 8, init 0, max 9, step 4, en held high -> count 0, 4, 8, then wrap_o = 1 and count 0; sticky_o = 1 from the wrap edge.
REQ-036 Saturate test: saturate_p 1, max 200, step 15, count 195, en -> wrap_o = 1, count 200; repeated en -> count stays 200 with wrap_o = 1 each cycle.
REQ-037 Cascade test: els_p 3, cascade_p 1, max 1 for all channels, step 1, all en high -> counts follow a binary-style ripple; all three wrap_o high in the same cycle at 1,1,1, then all counts return to 0.
REQ-038 Priority test: clear_i and sticky_clr_i in the same cycle as a wrap -> count equals init, sticky_o = 1 (set wins), and the downstream cascade channel still advances.
REQ-039 Reset test: assert reset_n_i asynchronously mid-count at 7 -> count_o goes to init and sticky_o to 0 before the next edge; en on the first post-release edge -> count = init + step.
REQ-040 Limit test: max lowered from 50 to 10 while count = 30, en with step 1 -> wrap, count = init; without en -> count holds at 30.
